// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller: tracks in-flight register writes from EX to WB,
// drives operand forwarding selects, load-use stalls and branch flushes.
// Optional feature macro: HAZARD_FORWARD_EN (forwarding); undefined = stall-only.
module pipeline_hazard_ctrl #(
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned BR_STAGE   = 3,
  parameter int unsigned LOAD_READY = 2,
  parameter int unsigned REG_W      = 5,
  parameter int unsigned FWD_W      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_w_reg,
  input  logic             id_is_load,
  input  logic             br_taken,
  output logic             stall,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [FWD_W-1:0] fwd_a,
  output logic [FWD_W-1:0] fwd_b,
  output logic [31:0]      stall_count
);

  logic [DEPTH:1]            sb_valid;
  logic [DEPTH:1]            sb_load;
  logic [DEPTH:1][REG_W-1:0] sb_rd;

  logic             id_req;
  logic             found_a, found_b;
  logic             load_a, load_b;
  logic [FWD_W-1:0] sel_a, sel_b;
  logic             lu_a, lu_b;
  logic             hz_a, hz_b;
  logic [FWD_W-1:0] fwd_a_int, fwd_b_int;
  logic             stall_int;

  assign id_req = id_valid & id_w_reg & (id_rd != '0);

  // Youngest (lowest stage number) matching producer wins for each operand.
  always_comb begin
    found_a = 1'b0;
    load_a  = 1'b0;
    sel_a   = '0;
    found_b = 1'b0;
    load_b  = 1'b0;
    sel_b   = '0;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      if (!found_a && id_use_rs1 && (id_rs1 != '0) && sb_valid[k] && (sb_rd[k] == id_rs1)) begin
        found_a = 1'b1;
        load_a  = sb_load[k];
        sel_a   = FWD_W'(k);
      end
      if (!found_b && id_use_rs2 && (id_rs2 != '0) && sb_valid[k] && (sb_rd[k] == id_rs2)) begin
        found_b = 1'b1;
        load_b  = sb_load[k];
        sel_b   = FWD_W'(k);
      end
    end
  end

  assign lu_a = found_a & load_a & (32'(sel_a) < LOAD_READY);
  assign lu_b = found_b & load_b & (32'(sel_b) < LOAD_READY);

`ifdef HAZARD_FORWARD_EN
  assign hz_a      = lu_a;
  assign hz_b      = lu_b;
  assign fwd_a_int = lu_a ? '0 : sel_a;
  assign fwd_b_int = lu_b ? '0 : sel_b;
`else
  // Register file has no write-through, so any in-flight producer must drain first.
  logic unused_fwd;
  assign unused_fwd = ^{lu_a, lu_b, sel_a, sel_b};
  assign hz_a      = found_a;
  assign hz_b      = found_b;
  assign fwd_a_int = '0;
  assign fwd_b_int = '0;
`endif

  assign stall_int   = ~reset & id_valid & (hz_a | hz_b) & ~br_taken;
  assign stall       = stall_int;
  assign flush_if_id = ~reset & br_taken;
  assign flush_id_ex = ~reset & (br_taken | stall_int);
  assign fwd_a       = reset ? '0 : fwd_a_int;
  assign fwd_b       = reset ? '0 : fwd_b_int;

  always_ff @(posedge clk) begin
    if (reset) begin
      sb_valid    <= '0;
      sb_load     <= '0;
      sb_rd       <= '0;
      stall_count <= '0;
    end else begin
      sb_valid[1] <= id_req & ~stall_int & ~br_taken;
      sb_load[1]  <= id_is_load;
      sb_rd[1]    <= id_rd;
      // A taken branch kills everything younger than itself; it moves on to BR_STAGE+1.
      for (int unsigned k = 2; k <= DEPTH; k++) begin
        sb_valid[k] <= sb_valid[k-1] & ~(br_taken & (k <= BR_STAGE));
        sb_load[k]  <= sb_load[k-1];
        sb_rd[k]    <= sb_rd[k-1];
      end
      if (stall_int && (stall_count != '1))
        stall_count <= stall_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (default parameters); expectations
// follow whichever build (HAZARD_FORWARD_EN defined or not) is compiled.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2, id_w_reg, id_is_load, br_taken;
  logic        stall, flush_if_id, flush_id_ex;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_count;

  pipeline_hazard_ctrl #(
    .DEPTH(3), .BR_STAGE(3), .LOAD_READY(2), .REG_W(5), .FWD_W(2)
  ) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_w_reg(id_w_reg), .id_is_load(id_is_load), .br_taken(br_taken),
    .stall(stall), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // {stall, flush_if_id, flush_id_ex, fwd_a, fwd_b}
  logic [6:0] obs;
  assign obs = {stall, flush_if_id, flush_id_ex, fwd_a, fwd_b};

  localparam logic [6:0] Z  = 7'b000_00_00;
  localparam logic [6:0] ST = 7'b101_00_00;

  typedef struct packed {
    logic       rst, vld;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       w, ld, br;
    logic [6:0] exp;
  } row_t;

  logic [6:0]  sb[$];
  int unsigned exp_count = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  function automatic logic [6:0] ex(input logic st, fi, fe, input logic [1:0] fa, fb);
    return {st, fi, fe, fa, fb};
  endfunction

  // ef: expectation with forwarding enabled, en: stall-only build.
  function automatic row_t r(input logic rst, vld, input logic [4:0] rs1, input logic u1,
                             input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                             input logic w, ld, br, input logic [6:0] ef, en);
    row_t t;
    t.rst = rst; t.vld = vld; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2;
    t.rd = rd; t.w = w; t.ld = ld; t.br = br;
`ifdef HAZARD_FORWARD_EN
    t.exp = ef;
`else
    t.exp = en;
`endif
    return t;
  endfunction

  function automatic row_t wr(input logic [4:0] rd, input logic ld);
    return r(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, rd, 1'b1, ld, 1'b0, Z, Z);
  endfunction

  function automatic row_t rdop(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                                input logic u2, input logic [6:0] ef, en);
    return r(1'b0, 1'b1, rs1, u1, rs2, u2, 5'd0, 1'b0, 1'b0, 1'b0, ef, en);
  endfunction

  task automatic apply(input row_t rw);
    reset = rw.rst; id_valid = rw.vld; id_rs1 = rw.rs1; id_use_rs1 = rw.u1;
    id_rs2 = rw.rs2; id_use_rs2 = rw.u2; id_rd = rw.rd; id_w_reg = rw.w;
    id_is_load = rw.ld; br_taken = rw.br;
    sb.push_back(rw.exp);
    if (rw.rst) exp_count = 0;
    else if (rw.exp[6]) exp_count++;
  endtask

  task automatic test_reset;
    row_t rows[2];
    logic [6:0] e;
    rows = '{r(1'b1, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, Z, Z),
             r(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, Z, Z)};
    foreach (rows[i]) begin
      apply(rows[i]); #1; e = sb.pop_front(); n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL reset[%0d] outputs got %b want %b", i, obs, e); end
      @(negedge clk);
    end
    n_tests++;
    if (stall_count !== exp_count) begin n_fail++; $display("FAIL reset count got %0d want %0d", stall_count, exp_count); end
  endtask

  task automatic test_alu_forward;
    row_t rows[5];
    logic [6:0] e;
    rows = '{wr(5'd5, 1'b0),
             rdop(5'd5, 1'b1, 5'd3, 1'b1, ex(0,0,0,2'd1,2'd0), ST),
             rdop(5'd5, 1'b1, 5'd3, 1'b1, ex(0,0,0,2'd2,2'd0), ST),
             rdop(5'd5, 1'b1, 5'd3, 1'b1, ex(0,0,0,2'd3,2'd0), ST),
             rdop(5'd5, 1'b1, 5'd3, 1'b1, Z, Z)};
    foreach (rows[i]) begin
      apply(rows[i]); #1; e = sb.pop_front(); n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL alu_fwd[%0d] outputs got %b want %b", i, obs, e); end
      @(negedge clk);
    end
    n_tests++;
    if (stall_count !== exp_count) begin n_fail++; $display("FAIL alu_fwd count got %0d want %0d", stall_count, exp_count); end
  endtask

  task automatic test_load_use;
    row_t rows[5];
    logic [6:0] e;
    rows = '{wr(5'd6, 1'b1),
             rdop(5'd0, 1'b0, 5'd6, 1'b1, ST, ST),
             rdop(5'd0, 1'b0, 5'd6, 1'b1, ex(0,0,0,2'd0,2'd2), ST),
             rdop(5'd0, 1'b0, 5'd6, 1'b1, ex(0,0,0,2'd0,2'd3), ST),
             rdop(5'd0, 1'b0, 5'd6, 1'b1, Z, Z)};
    foreach (rows[i]) begin
      apply(rows[i]); #1; e = sb.pop_front(); n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL load_use[%0d] outputs got %b want %b", i, obs, e); end
      @(negedge clk);
    end
    n_tests++;
    if (stall_count !== exp_count) begin n_fail++; $display("FAIL load_use count got %0d want %0d", stall_count, exp_count); end
  endtask

  task automatic test_branch;
    row_t rows[6];
    logic [6:0] e;
    rows = '{wr(5'd9, 1'b0), wr(5'd10, 1'b0), wr(5'd8, 1'b1),
             r(1'b0, 1'b1, 5'd8, 1'b1, 5'd10, 1'b1, 5'd11, 1'b1, 1'b0, 1'b1,
               ex(0,1,1,2'd0,2'd2), ex(0,1,1,2'd0,2'd0)),
             rdop(5'd8, 1'b1, 5'd10, 1'b1, Z, Z),
             rdop(5'd11, 1'b1, 5'd9, 1'b1, Z, Z)};
    foreach (rows[i]) begin
      apply(rows[i]); #1; e = sb.pop_front(); n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL branch[%0d] outputs got %b want %b", i, obs, e); end
      @(negedge clk);
    end
    n_tests++;
    if (stall_count !== exp_count) begin n_fail++; $display("FAIL branch count got %0d want %0d", stall_count, exp_count); end
  endtask

  task automatic test_x0;
    row_t rows[2];
    logic [6:0] e;
    rows = '{wr(5'd0, 1'b0), rdop(5'd0, 1'b1, 5'd0, 1'b1, Z, Z)};
    foreach (rows[i]) begin
      apply(rows[i]); #1; e = sb.pop_front(); n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL x0[%0d] outputs got %b want %b", i, obs, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    row_t rows[12];
    logic [6:0] e;
    rows = '{wr(5'd12, 1'b1), wr(5'd12, 1'b1),
             rdop(5'd12, 1'b1, 5'd0, 1'b0, ST, ST),
             rdop(5'd12, 1'b1, 5'd0, 1'b0, ex(0,0,0,2'd2,2'd0), ST),
             rdop(5'd12, 1'b1, 5'd0, 1'b0, ex(0,0,0,2'd3,2'd0), ST),
             rdop(5'd12, 1'b1, 5'd0, 1'b0, Z, Z),
             wr(5'd14, 1'b0), wr(5'd14, 1'b0),
             rdop(5'd0, 1'b0, 5'd14, 1'b1, ex(0,0,0,2'd0,2'd1), ST),
             rdop(5'd0, 1'b0, 5'd14, 1'b1, ex(0,0,0,2'd0,2'd2), ST),
             rdop(5'd0, 1'b0, 5'd14, 1'b1, ex(0,0,0,2'd0,2'd3), ST),
             rdop(5'd0, 1'b0, 5'd14, 1'b1, Z, Z)};
    foreach (rows[i]) begin
      apply(rows[i]); #1; e = sb.pop_front(); n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL back_to_back[%0d] outputs got %b want %b", i, obs, e); end
      @(negedge clk);
    end
    n_tests++;
    if (stall_count !== exp_count) begin n_fail++; $display("FAIL back_to_back count got %0d want %0d", stall_count, exp_count); end
  endtask

  task automatic test_reset_mid_stall;
    row_t rows[4];
    logic [6:0] e;
    rows = '{wr(5'd6, 1'b1),
             rdop(5'd6, 1'b1, 5'd0, 1'b0, ST, ST),
             r(1'b1, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, Z, Z),
             rdop(5'd6, 1'b1, 5'd0, 1'b0, Z, Z)};
    foreach (rows[i]) begin
      apply(rows[i]); #1; e = sb.pop_front(); n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL reset_mid_stall[%0d] outputs got %b want %b", i, obs, e); end
      @(negedge clk);
    end
    n_tests++;
    if (stall_count !== exp_count) begin n_fail++; $display("FAIL reset_mid_stall count got %0d want %0d", stall_count, exp_count); end
  endtask

  initial begin
    reset = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_w_reg = 1'b0; id_is_load = 1'b0; br_taken = 1'b0;
    @(negedge clk);
    test_reset;
    test_alu_forward;
    test_load_use;
    test_branch;
    test_x0;
    test_back_to_back;
    test_reset_mid_stall;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d tests", n_tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Parametrised hazard and forwarding controller for the pipelined RV32 core. It keeps a scoreboard of in-flight register writes for every stage after decode, from EX through WB. From that scoreboard it:
- drives forwarding selects for both ALU operands;
- generates load-use stalls;
- flushes younger instructions when a taken branch/jump is resolved.

It sits beside the ID stage and feeds the PC enable, the IF/ID and ID/EX pipeline register controls, and the EX operand muxes.

## Interface
Parameters:
- DEPTH, 3, number of tracked stages after ID (stage 1 = EX … stage DEPTH = WB); legal 2..8
- BR_STAGE, 3, stage whose redirect (pcsrc) is presented on br_taken; legal 1..DEPTH
- LOAD_READY, 2, first stage where load data is forwardable; legal 2..DEPTH
- REG_W, 5, register address width
- FWD_W, $clog2(DEPTH+1), width of forwarding selects

Ports:
- clk  input  1  core clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears scoreboard and counter
- id_valid  input  1  ID holds a real instruction
- id_rs1  input  REG_W  source register 1 of ID instruction
- id_rs2  input  REG_W  source register 2
- id_use_rs1  input  1  ID instruction reads rs1
- id_use_rs2  input  1  ID instruction reads rs2
- id_rd  input  REG_W  destination of ID instruction
- id_w_reg  input  1  ID instruction writes rd
- id_is_load  input  1  ID instruction is a load (r_dm nonzero)
- br_taken  input  1  instruction in stage BR_STAGE redirects PC this cycle
- stall  output  1  hold PC and IF/ID
- flush_if_id  output  1  clear IF/ID to bubble
- flush_id_ex  output  1  clear ID/EX to bubble
- fwd_a  output  FWD_W  operand-A source: 0 = register file, k = stage k result
- fwd_b  output  FWD_W  operand-B source, same encoding
- stall_count  output  32  saturating count of stall cycles

## Operation
- Scoreboard entry k (1..DEPTH) holds {valid, rd, is_load} for the instruction in stage k.
- ID write request: id_valid & id_w_reg & (id_rd != 0).
- A source matches entry k when all of the following hold:
  - the source is used;
  - the source register is nonzero;
  - entry k is valid;
  - entry k rd equals the source register.
- Match priority: the youngest match (lowest k) wins.
- Forwarding, per operand:
  - No match: select 0.
  - Youngest match is a load with k < LOAD_READY: raise load-use stall; the select is don't-care but driven 0.
  - Otherwise: select k.
- Stall: stall = id_valid & (load-use on either operand) & ~br_taken. A stall also asserts flush_id_ex, so a bubble enters EX.
- Taken branch: br_taken asserts flush_if_id and flush_id_ex and forces stall = 0. Taken branch has priority over stall.
- Scoreboard shift on every clock:
  - entry 1 takes the ID request, or an invalid entry when stall or br_taken is asserted;
  - entry k takes entry k-1 for k ≥ 2.
- Branch kill: on br_taken, entries that will land in stages 2..BR_STAGE are written invalid. These are the younger instructions. The branch itself continues to BR_STAGE+1.
- stall_count increments on each cycle with stall = 1. It holds at 32'hFFFF_FFFF.

## Timing
- All outputs are combinational from the current scoreboard plus ID and br_taken inputs, with zero-cycle latency.
- Scoreboard and counter update at the rising clk edge.
- Under reset:
  - all entries are invalid and stall_count = 0;
  - stall, flush_if_id and flush_id_ex evaluate to 0;
  - fwd_a and fwd_b evaluate to 0.
- Reset asserted mid-stall drops all in-flight hazards the next cycle.
- A load-use stall lasts LOAD_READY−1 cycles: with the default LOAD_READY = 2, exactly 1 cycle.
- Two back-to-back loads feeding a consumer: the youngest producer governs the outcome.
- br_taken and a load-use in the same cycle: flush only, no stall, and stall_count does not increment.
- rd = x0 never creates an entry, and never stalls or forwards.

## Configuration
- HAZARD_FORWARD_EN defined:
  - forwarding as described;
  - only load-use with k < LOAD_READY stalls.
- HAZARD_FORWARD_EN undefined:
  - fwd_a and fwd_b are tied to 0;
  - any match in any stage 1..DEPTH stalls;
  - this is required because the register file is written at the WB clock edge without bypass.
- All other behaviour is identical in both builds.

## Test plan
- ALU dependency: add x5 in EX, ID reads rs1 = x5 → fwd_a = 1, stall = 0. Next cycle, same x5 in stage 2 → fwd_a = 2.
- Load-use: lw x6 in EX, ID reads rs2 = x6 → stall = 1 and flush_id_ex = 1 for 1 cycle, then fwd_b = 2, and stall_count = 1.
- Taken branch at stage 3 while ID has a load-use → flush_if_id = 1, flush_id_ex = 1, stall = 0. Entries for stages 2..3 are invalid next cycle, and the branch entry is in stage 4 only if DEPTH ≥ 4.
- x0 destination: addi x0 in EX, ID reads x0 → fwd_a = 0, stall = 0.
- Forwarding disabled build: add x7 in stage 3, ID reads x7 → stall = 1 for 1 cycle, fwd_a = 0. Matches in stages 1..3 give 3 stall cycles.
- Reset asserted during a stall → next cycle stall = 0, stall_count = 0, fwd_a = fwd_b = 0.
